// File: rtl/serial_add_sequencer_pkg.sv
// Shared encodings for the serial add/subtract sequencer: FSM states and op codes.
package serial_add_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_slice.sv
// One-bit serial full adder with its carry flop; the carry can be loaded
// (clear/preset) independently of the shift enable.
module serial_add_slice (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic load_val_i,
    input  logic shift_i,
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic cout_o,
    output logic carry_o
);

    logic carry_q, carry_d;

    assign sum_o   = a_i ^ b_i ^ carry_q;
    assign cout_o  = (a_i & b_i) | (carry_q & (a_i ^ b_i));
    assign carry_o = carry_q;

    // A load always wins over a shift so every new op starts from a known carry.
    always_comb begin
        carry_d = carry_q;
        if (load_i) begin
            carry_d = load_val_i;
        end else if (shift_i) begin
            carry_d = cout_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/serial_add_sequencer.sv
// Sequences an N-bit add/subtract through a 1-bit serial slice, LSB first,
// and presents the parallel sum, carry and signed overflow on a valid/ready handshake.
module serial_add_sequencer
    import serial_add_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             op_sub_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_out_o,
    output logic             overflow_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic accept;
    logic shift_en;
    logic last_bit;
    logic slice_sum, slice_cout, slice_carry;

    assign accept   = (state_q == ST_IDLE) && req_valid_i;
    assign shift_en = (state_q == ST_SHIFT);
    assign last_bit = shift_en && (cnt_q == CNT_W'(1));

    serial_add_slice u_slice (
        .clk_i      (clock_i),
        .rst_i      (reset_i),
        .load_i     (accept),
        .load_val_i (op_sub_i == OP_SUB),
        .shift_i    (shift_en),
        .a_i        (a_sr_q[0]),
        .b_i        (b_sr_q[0]),
        .sum_o      (slice_sum),
        .cout_o     (slice_cout),
        .carry_o    (slice_carry)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid_i)        state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
            ST_DONE:  if (res_ready_i)        state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;
        if (accept) begin
            a_sr_d   = op_a_i;
            b_sr_d   = op_b_i ^ {WIDTH{op_sub_i}};
            res_sr_d = '0;
            cnt_d    = CNT_W'(WIDTH);
        end else if (shift_en) begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            res_sr_d = {slice_sum, res_sr_q[WIDTH-1:1]};
            cnt_d    = cnt_q - CNT_W'(1);
        end
        // Carry flop still holds the carry into the MSB during the last shift.
        if (last_bit) begin
            sum_d   = {slice_sum, res_sr_q[WIDTH-1:1]};
            c_out_d = slice_cout;
            ovf_d   = slice_carry ^ slice_cout;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            cnt_q    <= '0;
            sum_q    <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign res_valid_o = (state_q == ST_DONE);
    assign busy_o      = (state_q == ST_SHIFT);
    assign sum_o       = sum_q;
    assign c_out_o     = c_out_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Bench for serial_add_sequencer (WIDTH=8): directed vectors, handshake corner
// cases and random ops checked against an arithmetic reference model.
module tb_serial_add_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] op_a = 8'h00;
    logic [7:0] op_b = 8'h00;
    logic       op_sub = 1'b0;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [7:0] sum;
    logic       c_out;
    logic       overflow;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_sequencer #(.WIDTH(8)) dut (
        .clock_i     (clk),
        .reset_i     (reset),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .op_sub_i    (op_sub),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .sum_o       (sum),
        .c_out_o     (c_out),
        .overflow_o  (overflow),
        .busy_o      (busy)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] s;
        logic       c;
        logic       v;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic, returns {overflow, carry, sum}.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic sub);
        int sa, sb, sr, ur;
        logic c, v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sr = sub ? sa - sb : sa + sb;
        ur = sub ? int'(a) - int'(b) : int'(a) + int'(b);
        v  = (sr > 127) || (sr < -128);
        c  = sub ? (ur >= 0) : (ur > 255);
        return {v, c, 8'(ur)};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic sub, output int acc_cyc);
        int n;
        n = 0;
        op_a = a;
        op_b = b;
        op_sub = sub;
        req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
        acc_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!res_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!res_valid) check("result_timeout", 32'(res_valid), 32'd1);
    endtask

    vec_t       vecs [6];
    int         acc, prev_acc, lat, n;
    logic [9:0] exp_r;
    logic [7:0] ra, rb;
    logic       rs;

    initial begin
        vecs[0] = '{a: 8'h5A, b: 8'h3C, sub: 1'b0, s: 8'h96, c: 1'b0, v: 1'b1};
        vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, s: 8'h00, c: 1'b1, v: 1'b0};
        vecs[2] = '{a: 8'h10, b: 8'h20, sub: 1'b1, s: 8'hF0, c: 1'b0, v: 1'b0};
        vecs[3] = '{a: 8'h80, b: 8'h01, sub: 1'b1, s: 8'h7F, c: 1'b1, v: 1'b1};
        vecs[4] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, s: 8'h80, c: 1'b0, v: 1'b1};
        vecs[5] = '{a: 8'h00, b: 8'h00, sub: 1'b1, s: 8'h00, c: 1'b1, v: 1'b0};

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_c_out",     32'(c_out),     32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].sub, acc);
            wait_result(lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
            check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].s));
            check($sformatf("vec%0d_c_out", i), 32'(c_out), 32'(vecs[i].c));
            check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].v));
        end

        // Backpressure, with a stray request during SHIFT.
        @(negedge clk);
        res_ready = 1'b0;
        issue(8'h12, 8'h34, 1'b0, acc);
        @(negedge clk);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_shift_req_ready", 32'(req_ready), 32'd0);
        req_valid = 1'b1;
        op_a = 8'hFF;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("bp_res_valid", 32'(res_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", k), 32'(res_valid), 32'd1);
            check($sformatf("bp_hold%0d_sum", k), 32'(sum), 32'h46);
            check($sformatf("bp_hold%0d_c_out", k), 32'(c_out), 32'd0);
            check($sformatf("bp_hold%0d_req_ready", k), 32'(req_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(res_valid), 32'd0);
        check("bp_release_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("bp_no_queued_op", 32'(busy), 32'd0);

        // Reset in the middle of a shift, then a clean op.
        issue(8'hAA, 8'h55, 1'b0, acc);
        repeat (3) @(negedge clk);
        check("midrst_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_busy",      32'(busy),      32'd0);
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        check("midrst_sum",       32'(sum),       32'd0);
        check("midrst_c_out",     32'(c_out),     32'd0);
        check("midrst_overflow",  32'(overflow),  32'd0);
        reset = 1'b0;
        @(negedge clk);
        issue(8'h01, 8'h01, 1'b0, acc);
        wait_result(lat);
        check("postrst_latency",  32'(lat),      32'd9);
        check("postrst_sum",      32'(sum),      32'h02);
        check("postrst_c_out",    32'(c_out),    32'd0);
        check("postrst_overflow", 32'(overflow), 32'd0);

        // Back-to-back random ops against the reference model.
        prev_acc = 0;
        for (int i = 0; i < 100; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            exp_r = model(ra, rb, rs);
            issue(ra, rb, rs, acc);
            wait_result(lat);
            if (i > 0) check($sformatf("rnd%0d_spacing", i), 32'(acc - prev_acc), 32'd10);
            prev_acc = acc;
            check($sformatf("rnd%0d_sum", i), 32'(sum), 32'(exp_r[7:0]));
            check($sformatf("rnd%0d_c_out", i), 32'(c_out), 32'(exp_r[8]));
            check($sformatf("rnd%0d_overflow", i), 32'(overflow), 32'(exp_r[9]));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
